// File: rtl/cnt_seq_ctrl.sv
// Two-counter accumulate sequencer: counts A and B together until B hits its limit,
// then A alone until A hits its limit, and offers A+B on a valid/ready handshake.
module cnt_seq_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] lim_a,
  input  logic [W-1:0] lim_b,
  output logic [W-1:0] cnt_a,
  output logic [W-1:0] cnt_b,
  output logic [1:0]   phase,
  output logic         busy,
  output logic [W:0]   sum,
  output logic         sum_valid,
  input  logic         sum_ready,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOTH   = 2'd1,
    ONLY_A = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t       state;
  logic [W-1:0] lim_a_r;
  logic [W-1:0] lim_b_r;

  // phase mirrors the state register, so it is a flop output by construction
  assign phase = 2'(state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt_a     <= '0;
      cnt_b     <= '0;
      lim_a_r   <= '0;
      lim_b_r   <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // abort freezes counters and drops any pending result without a done pulse
        state     <= IDLE;
        busy      <= 1'b0;
        sum_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              lim_a_r <= lim_a;
              lim_b_r <= lim_b;
              cnt_a   <= '0;
              cnt_b   <= '0;
              busy    <= 1'b1;
              state   <= BOTH;
            end
          end
          BOTH: begin
            cnt_a <= cnt_a + W'(1);
            if (cnt_b == lim_b_r) begin
              state <= ONLY_A;
            end else begin
              cnt_b <= cnt_b + W'(1);
            end
          end
          ONLY_A: begin
            if (cnt_a == lim_a_r) begin
              sum       <= (W+1)'(cnt_a) + (W+1)'(cnt_b);
              sum_valid <= 1'b1;
              state     <= RESULT;
            end else begin
              cnt_a <= cnt_a + W'(1);
            end
          end
          RESULT: begin
            if (sum_valid && sum_ready) begin
              sum_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: normal runs, lim_b=0, wrap, backpressure, abort, reset.
module tb_cnt_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] lim_a;
  logic [3:0] lim_b;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;
  logic [1:0] phase;
  logic       busy;
  logic [4:0] sum;
  logic       sum_valid;
  logic       sum_ready;
  logic       done;

  int checks   = 0;
  int failures = 0;

  cnt_seq_ctrl #(.W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .lim_a     (lim_a),
    .lim_b     (lim_b),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .phase     (phase),
    .busy      (busy),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a run and follow it to the handshake; latency counts edges inclusively
  // from the start-sampling edge to the edge that raises sum_valid.
  task automatic run_case(input string name, input logic [3:0] la, input logic [3:0] lb,
                          input int exp_lat, input int exp_sum,
                          input int exp_ea, input int exp_eb, input int exp_wrap);
    int   cycles;
    int   ea;
    int   eb;
    logic seen;
    logic wrapped;
    seen    = 1'b0;
    wrapped = 1'b0;
    ea      = -1;
    eb      = -1;
    lim_a   = la;
    lim_b   = lb;
    start   = 1'b1;
    tick();
    cycles = 1;
    start  = 1'b0;
    lim_a  = ~la;
    lim_b  = ~lb;
    check({name, "_phase_both"}, 32'(phase), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd1);
    while (!sum_valid && cycles < 200) begin
      tick();
      cycles++;
      if (phase == 2'd2 && !seen) begin
        seen = 1'b1;
        ea   = int'(cnt_a);
        eb   = int'(cnt_b);
      end
      if (phase == 2'd2 && cnt_a == 4'd0) wrapped = 1'b1;
    end
    check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({name, "_sum"}, 32'(sum), 32'(exp_sum));
    check({name, "_entry_a"}, 32'(ea), 32'(exp_ea));
    check({name, "_entry_b"}, 32'(eb), 32'(exp_eb));
    check({name, "_wrap"}, 32'(wrapped), 32'(exp_wrap));
    tick();
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_valid_low"}, 32'(sum_valid), 32'd0);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
    check({name, "_sum_kept"}, 32'(sum), 32'(exp_sum));
    tick();
    check({name, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    lim_a     = 4'd0;
    lim_b     = 4'd0;
    sum_ready = 1'b1;
    repeat (2) tick();
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_valid", 32'(sum_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    run_case("basic", 4'd9, 4'd4, 11, 13, 5, 4, 0);
    run_case("limb0", 4'd5, 4'd0, 7, 5, 1, 0, 0);
    run_case("wrap", 4'd2, 4'd4, 20, 6, 5, 4, 1);

    // Backpressure: result must hold steady while the consumer stalls
    sum_ready = 1'b0;
    lim_a     = 4'd3;
    lim_b     = 4'd1;
    start     = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 1;
    while (!sum_valid && cycles < 200) begin
      tick();
      cycles++;
    end
    check("bp_latency", 32'(cycles), 32'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", 32'(sum_valid), 32'd1);
      check("bp_sum_hold", 32'(sum), 32'd4);
      check("bp_no_done", 32'(done), 32'd0);
      check("bp_phase", 32'(phase), 32'd3);
    end
    sum_ready = 1'b1;
    tick();
    check("bp_done", 32'(done), 32'd1);
    check("bp_valid_low", 32'(sum_valid), 32'd0);
    check("bp_phase_idle", 32'(phase), 32'd0);

    // Abort one cycle into ONLY_A: entry gives a=3,b=2, one more edge a=4
    lim_a = 4'd9;
    lim_b = 4'd2;
    start = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 1;
    while (phase != 2'd2 && cycles < 50) begin
      tick();
      cycles++;
    end
    check("ab_entry_a", 32'(cnt_a), 32'd3);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_phase", 32'(phase), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_cnt_a", 32'(cnt_a), 32'd4);
    check("ab_cnt_b", 32'(cnt_b), 32'd2);
    repeat (3) tick();
    check("ab_frozen_a", 32'(cnt_a), 32'd4);
    check("ab_no_valid", 32'(sum_valid), 32'd0);
    check("ab_no_done", 32'(done), 32'd0);

    // start and abort together in IDLE: start ignored, counters not cleared
    lim_a = 4'd7;
    lim_b = 4'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_phase", 32'(phase), 32'd0);
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_cnt_a", 32'(cnt_a), 32'd4);
    tick();
    check("sa_still_idle", 32'(phase), 32'd0);

    // start while busy must not relatch limits or clear counters
    lim_a = 4'd8;
    lim_b = 4'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    lim_a = 4'd2;
    lim_b = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sb_cnt_a", 32'(cnt_a), 32'd3);
    check("sb_cnt_b", 32'(cnt_b), 32'd3);
    check("sb_phase", 32'(phase), 32'd1);
    cycles = 0;
    while (!sum_valid && cycles < 200) begin
      tick();
      cycles++;
    end
    check("sb_sum", 32'(sum), 32'd14);
    tick();
    check("sb_done", 32'(done), 32'd1);

    // Asynchronous reset between edges in the middle of BOTH
    lim_a = 4'd8;
    lim_b = 4'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ar_pre_phase", 32'(phase), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_cnt_a", 32'(cnt_a), 32'd0);
    check("ar_cnt_b", 32'(cnt_b), 32'd0);
    check("ar_phase", 32'(phase), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_sum", 32'(sum), 32'd0);
    check("ar_valid", 32'(sum_valid), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("ar_idle_after", 32'(phase), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Sequencing controller for a two-counter accumulate datapath with counters A and B.
- On a start command it latches two programmable limits, then runs two phases: both counters count until B reaches its limit, then only A counts until A reaches its limit.
- It then presents the registered sum A+B on a valid/ready output handshake.
- Sits between a host/command source and a downstream consumer of the count result; supports abort and reports busy/phase.

Parameters:
- W, 4, width of each counter and limit (counters wrap modulo 2^W).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- abort  in  1  cancel the current run; highest priority.
- lim_a  in  W  A-phase terminal value; latched on accepted start.
- lim_b  in  W  B terminal value; latched on accepted start.
- cnt_a  out  W  current counter A value.
- cnt_b  out  W  current counter B value.
- phase  out  2  0=IDLE, 1=BOTH, 2=ONLY_A, 3=RESULT.
- busy  out  1  high whenever phase != IDLE.
- sum  out  W+1  registered cnt_a+cnt_b, no truncation.
- sum_valid  out  1  sum available.
- sum_ready  in  1  consumer accepts sum.
- done  out  1  one-cycle pulse on completed handshake.

Behaviour:
- Reset (async, any time, including mid-run):
  - State IDLE.
  - cnt_a, cnt_b, sum, internal limit registers = 0.
  - sum_valid = 0, done = 0, busy = 0, phase = 0.
- All outputs are registered.
- IDLE:
  - start=1 and abort=0: latch lim_a/lim_b, clear both counters to 0, go to BOTH on the next edge.
  - Otherwise hold; counters keep their last values.
- BOTH:
  - If cnt_b == lim_b_r: cnt_a += 1, cnt_b holds, go to ONLY_A.
  - Else: cnt_a += 1 and cnt_b += 1, stay in BOTH.
- ONLY_A:
  - If cnt_a == lim_a_r: counters hold, sum <= cnt_a + cnt_b, sum_valid <= 1, go to RESULT.
  - Else: cnt_a += 1, stay in ONLY_A.
- RESULT:
  - sum and sum_valid are held stable until sum_ready=1.
  - On the cycle with sum_valid && sum_ready: next edge sum_valid <= 0, done <= 1 for exactly one cycle, go to IDLE.
  - sum keeps its value afterwards.
  - sum_ready while not valid is ignored.
- abort:
  - abort=1 in BOTH, ONLY_A or RESULT: go to IDLE on the next edge.
  - Counters hold, sum_valid <= 0, no done pulse.
  - abort beats start in the same cycle, including in IDLE, where start is ignored.
- start while busy: ignored, no effect on limits or counters.
- Wrap: counters increment modulo 2^W.
  - If lim_a_r <= lim_b_r, A passes its limit on entry to ONLY_A and wraps before matching.
  - This is deterministic, not an error.
- lim_b = 0: first BOTH cycle matches immediately; enters ONLY_A with cnt_a = 1, cnt_b = 0.
- Latency, measured from the start-sampling edge to sum_valid high:
  - lim_a_r > lim_b_r: lim_a_r + 2 cycles.
  - Otherwise: lim_a_r + 2^W + 2 cycles.
- Limits are changeable on the input ports during a run without effect; only the latched copies are used.

Test Plan:
- Reset, then start with lim_b=4, lim_a=9, sum_ready=1 → phase BOTH until cnt_b=4, ONLY_A with cnt_a=5; sum_valid rises 11 cycles after start with sum=13; done pulses 1 cycle; busy falls.
- lim_b=0, lim_a=5 → ONLY_A entered with cnt_a=1, cnt_b=0; sum_valid at cycle 7; sum=5.
- lim_b=4, lim_a=2 (W=4), the wrap case → cnt_a wraps 15→0; sum_valid at cycle 20; sum=6.
- Backpressure: sum_ready=0 for 5 cycles in RESULT → sum_valid and sum stay stable; no done; raising sum_ready gives done one cycle later.
- abort mid-ONLY_A, plus start+abort together in IDLE → IDLE next cycle, counters frozen, no sum_valid/done; start is ignored in the simultaneous case.
- Async reset asserted mid-BOTH between clock edges → all outputs 0 immediately; start pulse while busy is ignored (limits unchanged).
